gcd_modulo_unit: RTL and testbench
==================================

Name: gcd_modulo_unit

Overview:
- Iterative remainder unit directly downstream of the GCD controller.
- Computes rem = a mod b by restoring shift-subtract, one dividend bit per clock.
- The controller holds start high while it waits. This block returns a one-cycle ready pulse and a registered remainder that the controller then writes back.
- The controller drives start as a level, so start acceptance is level-based with re-trigger protection.

Parameters:
- WIDTH, 16, operand and remainder width in bits (>= 2).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  level request; sampled only in IDLE and CALC.
- a_i  in  WIDTH  dividend; sampled on the accepting edge only.
- b_i  in  WIDTH  divisor; sampled on the accepting edge only.
- ready_o  out  1  registered; high exactly one cycle when rem_o is valid.
- rem_o  out  WIDTH  registered remainder; held until the next DONE.
- busy_o  out  1  registered; high in CALC.
- div_zero_o  out  1  registered; high alongside ready_o when b was 0, held until the next accept.

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, ready_o=0, busy_o=0, div_zero_o=0, rem_o=0, internal registers=0.
- rst dominates every other input, including mid-CALC, and aborts without a ready pulse.
- States: IDLE, CALC, DONE, HOLD.
- IDLE, start_i=1 (accepting edge):
  - Latch a_q=a_i, b_q=b_i, R=0 (WIDTH+1 bits), cnt=WIDTH-1, clear div_zero_o.
  - If b_i==0: rem_o<=a_i, div_zero_o<=1, go to DONE.
  - Otherwise go to CALC with busy_o<=1.
- CALC, per edge:
  - T={R[WIDTH-1:0], a_q[cnt]}.
  - R<=(T>=b_q) ? T-b_q : T.
  - Comparison and subtraction are WIDTH+1 bits wide and unsigned; no truncation before the compare.
  - When cnt==0: rem_o<=final R[WIDTH-1:0], busy_o<=0, go to DONE. Otherwise cnt<=cnt-1.
- CALC with start_i=0 (abort, e.g. controller forced to IDLE by valid):
  - Go to IDLE, busy_o<=0.
  - rem_o and div_zero_o keep their previous values; no ready pulse.
  - Abort has priority over the last-bit transition.
- DONE:
  - ready_o=1 for this cycle only.
  - Next edge: start_i=1 goes to HOLD; start_i=0 goes to IDLE.
- HOLD: ready_o=0. Stay until start_i=0, then go to IDLE. This guarantees one result per start level, with no re-trigger while start is still high.
- Latency:
  - b!=0: ready_o rises WIDTH+1 edges after the accepting edge.
  - b==0: ready_o rises 1 edge after the accepting edge.
- Results:
  - a<b yields rem=a via the normal path; no shortcut.
  - a==0 yields rem 0.
  - a mod 0 is defined as a.
- Operand changes on a_i/b_i after the accepting edge have no effect.
- A new accept requires the IDLE state; start edges during CALC/DONE/HOLD are not new requests.

Test Plan:
- WIDTH=16: a=100, b=7, start held high -> ready_o high exactly once, 17 edges after accept; rem_o=2, div_zero_o=0. After start drops: IDLE, rem_o stays 2.
- a=5, b=9 -> rem_o=5. Then a=0xFFFF, b=1 -> rem_o=0. Then a=0xFFFF, b=0xFFFF -> rem_o=0, each with 17-edge latency.
- a=42, b=0 -> ready_o one edge after accept; rem_o=42, div_zero_o=1. Next accept with b=3 clears div_zero_o on the accepting edge.
- Start held high 60 cycles with a=48, b=18 -> exactly one ready pulse, rem_o=12, and HOLD until start falls.
- Abort: previous rem_o=12; start a=1000, b=7, drop start 5 edges into CALC -> no ready pulse, rem_o stays 12, busy_o=0. Restart with a=1000, b=7 -> rem_o=6.
- rst asserted mid-CALC -> next edge: IDLE, all outputs 0, no ready. Fresh start a=81, b=27 -> rem_o=0.

Source files
------------

// File: rtl/gcd_modulo_unit.sv
// gcd_modulo_unit: iterative rem = a mod b by restoring shift-subtract, one dividend bit per clock.
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start_i     level request from the GCD controller (sampled in IDLE and CALC)
//   a_i, b_i    dividend / divisor, latched on the accepting edge
//   ready_o     one-cycle pulse when rem_o is valid
//   rem_o       registered remainder, held until the next result
//   busy_o      high while iterating
//   div_zero_o  set with the result when b was 0, cleared on the next accept
module gcd_modulo_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             busy_o,
    output logic             div_zero_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE, HOLD} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, r, r_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   t;
    logic             ge, accept, step;
    always_comb begin
        // partial remainder stays below b, so WIDTH bits hold it; t is compared at full width
        t        = {r, a_q[cnt]};
        ge       = t >= {1'b0, b_q};
        r_nx     = ge ? WIDTH'(t - {1'b0, b_q}) : t[WIDTH-1:0];
        accept   = state == IDLE && start_i;
        step     = state == CALC && start_i;
        state_nx = state;
        case (state)
            IDLE: state_nx = start_i ? (b_i == '0 ? DONE : CALC) : IDLE;
            // dropping start aborts and wins over the final-bit transition
            CALC: state_nx = !start_i ? IDLE : (cnt == '0 ? DONE : CALC);
            DONE: state_nx = start_i ? HOLD : IDLE;
            HOLD: state_nx = start_i ? HOLD : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            r          <= '0;
            cnt        <= '0;
            rem_o      <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            state   <= state_nx;
            // ready trails DONE by one edge, giving WIDTH+1 / 1 edge latency
            ready_o <= state == DONE;
            busy_o  <= state_nx == CALC;
            if (accept) begin
                a_q        <= a_i;
                b_q        <= b_i;
                r          <= '0;
                cnt        <= CNT_W'(WIDTH - 1);
                div_zero_o <= b_i == '0;
                if (b_i == '0) rem_o <= a_i;
            end
            if (step) begin
                r   <= r_nx;
                cnt <= cnt - 1'b1;
                if (cnt == '0) rem_o <= r_nx;
            end
        end
    end
endmodule

// File: tb/tb_gcd_modulo_unit.sv
// tb_gcd_modulo_unit: directed self-checking bench for gcd_modulo_unit.
module tb_gcd_modulo_unit;
    logic        clk = 1'b0;
    logic        rst, start_i, ready_o, busy_o, div_zero_o;
    logic [15:0] a_i, b_i, rem_o;
    int          vectors = 0;
    int          miscompares = 0;

    gcd_modulo_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .a_i(a_i), .b_i(b_i),
        .ready_o(ready_o), .rem_o(rem_o), .busy_o(busy_o), .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp_rem, input int exp_lat, input logic exp_dz, input int hold);
        int first, pulses;
        @(negedge clk);
        a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_accept_dz"}, div_zero_o, exp_dz);
        check({tag, "_accept_busy"}, busy_o, b != 0);
        a_i = ~a; b_i = b ^ 16'h5a5a;
        first = 0; pulses = 0;
        for (int n = 1; n <= hold; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o) begin
                pulses++;
                if (first == 0) first = n;
            end
            if (ready_o && pulses == 1) begin
                check({tag, "_rem"}, rem_o, exp_rem);
                check({tag, "_dz"}, div_zero_o, exp_dz);
                check({tag, "_busy_at_ready"}, busy_o, 0);
            end
        end
        check({tag, "_latency"}, first, exp_lat);
        check({tag, "_pulses"}, pulses, 1);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_idle_busy"}, busy_o, 0);
        check({tag, "_idle_ready"}, ready_o, 0);
        check({tag, "_idle_rem"}, rem_o, exp_rem);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start_i = 1'b0; a_i = 16'h1234; b_i = 16'h0005;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", ready_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_rem", rem_o, 0);
        check("reset_dz", div_zero_o, 0);
        rst = 1'b0;

        op("a100_b7", 16'd100, 16'd7, 16'd2, 17, 1'b0, 25);
        op("a5_b9", 16'd5, 16'd9, 16'd5, 17, 1'b0, 25);
        op("ffff_b1", 16'hffff, 16'd1, 16'd0, 17, 1'b0, 25);
        op("ffff_ffff", 16'hffff, 16'hffff, 16'd0, 17, 1'b0, 25);
        op("a42_b0", 16'd42, 16'd0, 16'd42, 1, 1'b1, 25);
        op("a10_b3", 16'd10, 16'd3, 16'd1, 17, 1'b0, 25);
        op("a48_b18_hold", 16'd48, 16'd18, 16'd12, 17, 1'b0, 60);

        // abort five edges into CALC
        @(negedge clk);
        a_i = 16'd1000; b_i = 16'd7; start_i = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_busy_before", busy_o, 1);
        start_i = 1'b0;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_rem", rem_o, 16'd12);
        check("abort_busy", busy_o, 0);
        op("restart_1000_7", 16'd1000, 16'd7, 16'd6, 17, 1'b0, 25);

        // reset mid-CALC
        @(negedge clk);
        a_i = 16'd500; b_i = 16'd9; start_i = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", ready_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_rem", rem_o, 0);
        check("rst_mid_dz", div_zero_o, 0);
        rst = 1'b0; start_i = 1'b0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check("rst_mid_no_ready", pulses, 0);
        op("a81_b27", 16'd81, 16'd27, 16'd0, 17, 1'b0, 25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
